// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states,
// NOP encoding and fetch-address decode constants.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned NOP_INSN    = 0;
  localparam int unsigned WORD_OFFSET = 2;
  localparam logic [1:0]  ALIGN_MASK  = 2'b11;
  localparam int unsigned WAIT_CNT_W  = 4;

endpackage

// File: rtl/imem_array.sv
// Synchronous instruction store: one registered read port, one write port,
// read-before-write when both hit the same word on one edge.
module imem_array #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned INSN_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [INSN_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [INSN_WIDTH-1:0] wr_data
);

  logic [INSN_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [INSN_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: accepts one word-aligned byte address per handshake and
// answers after 1 + WAIT_CYCLES cycles, returning NOP with an error flag for bad addresses.
module imem_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSN_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  output logic [INSN_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [INSN_WIDTH-1:0] ld_data
);

  import imem_pkg::*;

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  accept;
  logic [INSN_WIDTH-1:0] arr_rd_data;

  assign word_idx     = req_addr[DEPTH_LOG2+WORD_OFFSET-1:WORD_OFFSET];
  assign misaligned   = (req_addr[WORD_OFFSET-1:0] & ALIGN_MASK) != '0;
  assign out_of_range = (req_addr >> (DEPTH_LOG2 + WORD_OFFSET)) != '0;

  // The array's read register doubles as the data holding register: it only
  // loads on acceptance, so later loads cannot disturb an in-flight response.
  imem_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .INSN_WIDTH(INSN_WIDTH)
  ) u_array (
    .clk     (clk),
    .rd_en   (accept),
    .rd_addr (word_idx),
    .rd_data (arr_rd_data),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;

    req_ready = !reset && (state_q == IDLE || state_q == RESP);
    accept    = req_valid && req_ready;

    unique case (state_q)
      IDLE: ;
      WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      err_d = misaligned || out_of_range;
      if (WAIT_CYCLES == 0) begin
        state_d = RESP;
      end else begin
        state_d    = WAIT;
        wait_cnt_d = WAIT_CNT_W'(WAIT_CYCLES - 1);
      end
    end

    // Error responses mask whatever word the array happened to return.
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_data  = (rsp_valid && !err_q) ? arr_rd_data : INSN_WIDTH'(NOP_INSN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (no wait states and three wait states)
// checked every cycle against a response-schedule model, plus directed scenarios.
module tb_imem_responder;

  localparam int unsigned NDUT = 2;
  localparam int unsigned WC0  = 0;
  localparam int unsigned WC1  = 3;

  logic             clk;
  logic [1:0]       rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_addr;
  logic [1:0]       rsp_valid;
  logic [1:0][31:0] rsp_data;
  logic [1:0]       rsp_err;
  logic [1:0]       ld_en;
  logic [1:0][9:0]  ld_addr;
  logic [1:0][31:0] ld_data;

  imem_responder #(
    .ADDR_WIDTH(32), .INSN_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(WC0)
  ) dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
  );

  imem_responder #(
    .ADDR_WIDTH(32), .INSN_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(WC1)
  ) dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          wc [2] = '{WC0, WC1};
  logic [31:0] mem_m [2][1024];
  int          last_acc [2] = '{-1, -1};
  bit          pend [2] = '{0, 0};
  int          due [2];
  logic [31:0] exp_data [2];
  bit          exp_err [2];

  // Ready whenever nothing is in flight or the in-flight answer is due now or earlier.
  function automatic bit mready(int k);
    return !rst[k] && (last_acc[k] < 0 || cyc >= last_acc[k] + wc[k]);
  endfunction

  // Advance one clock: update the model at the edge, then check every output of both DUTs.
  task automatic step();
    bit          acc [2];
    logic [31:0] a;
    bit          ev;
    logic [31:0] want_d;
    for (int k = 0; k < NDUT; k++) acc[k] = req_valid[k] && mready(k);
    @(posedge clk);
    cyc++;
    for (int k = 0; k < NDUT; k++) begin
      if (rst[k]) begin
        last_acc[k] = -1;
        pend[k]     = 0;
      end else if (acc[k]) begin
        a            = req_addr[k];
        pend[k]      = 1;
        due[k]       = cyc + wc[k];
        last_acc[k]  = cyc;
        exp_err[k]   = (a % 4 != 0) || (a >= 32'd4096);
        exp_data[k]  = exp_err[k] ? 32'h0 : mem_m[k][(a / 4) % 1024];
      end
      if (ld_en[k]) mem_m[k][ld_addr[k]] = ld_data[k];
    end
    #1;
    for (int k = 0; k < NDUT; k++) begin
      ev     = pend[k] && (due[k] == cyc);
      want_d = ev ? exp_data[k] : 32'h0;
      vectors++;
      if (req_ready[k] !== mready(k)) begin
        miscompares++;
        $display("FAIL req_ready dut%0d cyc %0d: got %b expected %b", k, cyc, req_ready[k], mready(k));
      end
      vectors++;
      if (rsp_valid[k] !== ev) begin
        miscompares++;
        $display("FAIL rsp_valid dut%0d cyc %0d: got %b expected %b", k, cyc, rsp_valid[k], ev);
      end
      vectors++;
      if (rsp_data[k] !== want_d) begin
        miscompares++;
        $display("FAIL rsp_data dut%0d cyc %0d: got %h expected %h", k, cyc, rsp_data[k], want_d);
      end
      vectors++;
      if (rsp_err[k] !== (ev && exp_err[k])) begin
        miscompares++;
        $display("FAIL rsp_err dut%0d cyc %0d: got %b expected %b", k, cyc, rsp_err[k], ev && exp_err[k]);
      end
      if (ev) pend[k] = 0;
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_addr  = '0;
    ld_en     = '0;
    ld_addr   = '0;
    ld_data   = '0;
  endtask

  // Hold reset while preloading every word through the load port.
  task automatic test_reset();
    idle_inputs();
    rst = 2'b11;
    for (int unsigned i = 0; i < 1024; i++) begin
      for (int k = 0; k < NDUT; k++) begin
        ld_en[k]   = 1'b1;
        ld_addr[k] = 10'(i);
        ld_data[k] = $urandom;
      end
      step();
      if (i == 0) begin
        vectors++;
        if (rsp_valid !== 2'b00 || rsp_err !== 2'b00 || req_ready !== 2'b00) begin
          miscompares++;
          $display("FAIL reset_outputs: got valid %b err %b ready %b expected 00 00 00", rsp_valid, rsp_err, req_ready);
        end
      end
    end
    idle_inputs();
    rst = 2'b00;
    step();
    vectors++;
    if (req_ready !== 2'b11) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b expected 11", req_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      ld_en   = 2'b11;
      ld_addr = {10'(i), 10'(i)};
      ld_data = {words[i], words[i]};
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'(4 * i);
      step();
      vectors++;
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== words[i] || rsp_err[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_fetch %0d: got v%b %h e%b expected v1 %h e0", i, rsp_valid[0], rsp_data[0], rsp_err[0], words[i]);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4] = '{32'hFFC, 32'h1000, 32'h6, 32'h8000_0004};
    bit          errs  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] want;
    for (int i = 0; i < 4; i++) begin
      want         = errs[i] ? 32'h0 : mem_m[0][1023];
      req_valid[0] = 1'b1;
      req_addr[0]  = addrs[i];
      step();
      vectors++;
      if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== errs[i] || rsp_data[0] !== want) begin
        miscompares++;
        $display("FAIL addr_decode %h: got v%b e%b %h expected v1 e%b %h", addrs[i], rsp_valid[0], rsp_err[0], rsp_data[0], errs[i], want);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_ld_collision();
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h4;
    ld_en[0]     = 1'b1;
    ld_addr[0]   = 10'd1;
    ld_data[0]   = 32'hAA;
    step();
    vectors++;
    if (rsp_data[0] !== 32'h22) begin
      miscompares++;
      $display("FAIL read_before_write: got %h expected 00000022", rsp_data[0]);
    end
    ld_en[0] = 1'b0;
    step();
    vectors++;
    if (rsp_data[0] !== 32'hAA) begin
      miscompares++;
      $display("FAIL read_after_load: got %h expected 000000aa", rsp_data[0]);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_wait();
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h4;
    step();
    for (int i = 1; i <= 3; i++) begin
      vectors++;
      if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_state N+%0d: got ready %b valid %b expected 0 0", i, req_ready[1], rsp_valid[1]);
      end
      step();
    end
    vectors++;
    if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 32'h22 || req_ready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_resp: got v%b %h ready %b expected v1 00000022 ready 1", rsp_valid[1], rsp_data[1], req_ready[1]);
    end
    step();
    req_valid[1] = 1'b0;
    vectors++;
    if (req_ready[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_reaccept: got ready %b expected 0", req_ready[1]);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset_midflight();
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h8;
    step();
    req_valid[1] = 1'b0;
    rst[1]       = 1'b1;
    step();
    vectors++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_reset: got valid %b ready %b expected 0 0", rsp_valid[1], req_ready[1]);
    end
    rst[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || rsp_data[1] !== 32'h0 || rsp_err[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle %0d: got v%b r%b %h e%b expected v0 r1 0 e0", i, rsp_valid[1], req_ready[1], rsp_data[1], rsp_err[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NDUT; k++) begin
        rst[k]       = ($urandom_range(0, 49) == 0);
        req_valid[k] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0, 1, 2, 3, 4: req_addr[k] = 4 * $urandom_range(0, 1023);
          5:             req_addr[k] = 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
          6:             req_addr[k] = $urandom;
          default:       req_addr[k] = ($urandom_range(0, 1) != 0) ? 32'hFFC : 32'h1000;
        endcase
        ld_en[k]   = ($urandom_range(0, 3) == 0);
        ld_addr[k] = 10'($urandom_range(0, 1023));
        ld_data[k] = $urandom;
      end
      step();
    end
    idle_inputs();
    rst = 2'b00;
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    rst = 2'b11;
    idle_inputs();
    test_reset();
    test_basic();
    test_errors();
    test_ld_collision();
    test_wait();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that serves fetch requests from the front end. It accepts one word-aligned byte address per handshake and returns the instruction word after a fixed latency of 1 + WAIT_CYCLES cycles. It flags misaligned or out-of-range addresses and returns NOP (0) for them. A separate load port writes program words before or during execution. It sits between the fetch stage and the instruction store, and stands in for real memory in simulation and on FPGA.

## Interface
- ADDR_WIDTH, 32, request byte-address width
- INSN_WIDTH, 32, instruction word width
- DEPTH_LOG2, 10, log2 of the number of words (1024 words)
- WAIT_CYCLES, 0, extra wait states per access (0..15)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  ADDR_WIDTH  fetch byte address
- rsp_valid  out  1  single-cycle pulse: rsp_data/rsp_err valid
- rsp_data  out  INSN_WIDTH  instruction word (0 = NOP on error)
- rsp_err  out  1  request was misaligned or out of range
- ld_en  in  1  load-port write strobe
- ld_addr  in  DEPTH_LOG2  load word index
- ld_data  in  INSN_WIDTH  load word

## Operation
- States: IDLE, WAIT, RESP.
- req_ready = !reset && (state==IDLE || state==RESP).
- Request accepted on an edge where req_valid && req_ready.
- Decode at acceptance:
  - word index = req_addr[DEPTH_LOG2+1:2]
  - misaligned = req_addr[1:0] != 0
  - out of range = any req_addr bit above DEPTH_LOG2+1 set
  - err = misaligned || out of range
- On acceptance: the array word (or 0 if err) is registered into a data holding register, and the err flag is registered.
  - If WAIT_CYCLES==0: next state RESP.
  - Otherwise: load the wait counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, next state RESP. Requests are not accepted in WAIT.
- RESP: rsp_valid=1 for exactly this cycle; rsp_data/rsp_err come from the holding register.
  - A new request accepted in RESP follows the same acceptance rules, so back-to-back throughput is 1/cycle when WAIT_CYCLES==0.
  - Otherwise next state IDLE.
- rsp_data is 0 in any cycle where rsp_valid=0.
- Load port: when ld_en=1, mem[ld_addr] <= ld_data on the edge.
  - Independent of the FSM; allowed in any state, including during reset.
  - Same-edge load and accepted read to the same word: the read returns the old word (read-before-write).
  - Loads after acceptance are not visible to the in-flight response.
- Memory array is not reset.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_err 0, wait counter 0. req_ready is 0 while reset=1.
- Latency: request accepted at edge N produces rsp_valid high during cycle N+1+WAIT_CYCLES.
- No response backpressure: the requester must sample rsp_* during the pulse.
- Reset mid-operation (WAIT or RESP): the in-flight request is dropped with no response; outputs take reset values on that edge.
- Throughput:
  - 1 request/cycle when WAIT_CYCLES==0
  - 1 request per (1+WAIT_CYCLES) cycles otherwise, since acceptance in RESP overlaps the response cycle
- req_ready is combinational from state and reset only; there is no req_valid→req_ready path.

## Structure
- Shared package imem_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), NOP_INSN=0, and address decode helper constants (word offset 2, alignment mask 2'b11).
- One sub-module: imem_array — single-port-read / single-port-write synchronous RAM, DEPTH_LOG2 x INSN_WIDTH, read-before-write.
- The FSM, wait counter, address decode and holding registers live in imem_responder.

## Test plan
- Reset, then load mem[0..3]=0x11,0x22,0x33,0x44; request 0x0,0x4,0x8,0xC on consecutive cycles (WAIT_CYCLES=0) → rsp_valid every cycle from cycle 1, rsp_data 0x11,0x22,0x33,0x44, rsp_err=0.
- Request 0x6 (misaligned) → one cycle later rsp_valid=1, rsp_err=1, rsp_data=0.
- Request 0x1000 with DEPTH_LOG2=10 (out of range) → rsp_valid=1, rsp_err=1, rsp_data=0.
- WAIT_CYCLES=3, request 0x4 at edge N with req_valid held high → req_ready=0 during cycles N+1..N+3, rsp_valid only in cycle N+4 with data 0x22; next acceptance at edge N+4.
- ld_en writing mem[1]=0xAA on the same edge as an accepted request to 0x4 → response 0x22; a following request to 0x4 → 0xAA.
- WAIT_CYCLES=3, assert reset in the cycle after acceptance → no rsp_valid pulse; after reset release, state IDLE, req_ready=1, all outputs 0.
